// File: rtl/ram_lsu.sv
// Load/store unit between an RV32I-style core request port and a single-port word RAM.
// Every store is a read-modify-write; faults are reported without touching the RAM.
module ram_lsu #(
  parameter int dataW       = 32,
  parameter int RAMAddrSize = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [2:0]             req_funct3,
  input  logic [31:0]            req_addr,
  input  logic [dataW-1:0]       req_wdata,
  output logic                   resp_valid,
  output logic [dataW-1:0]       resp_rdata,
  output logic                   resp_fault,
  output logic [RAMAddrSize-1:0] RAMAddr,
  output logic [dataW-1:0]       DataIn,
  output logic                   RAMWriteControl,
  input  logic [dataW-1:0]       RAMOut
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t           state, state_next;
  logic             accept;
  logic             req_fault;
  logic             write_q;
  logic [2:0]       funct3_q;
  logic [1:0]       lane_q;
  logic [dataW-1:0] wdata_q;

  // Replace the addressed byte/halfword (or the whole word) of the RAM word with store data.
  function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [2:0] funct3, input logic [1:0] lane);
    logic [31:0] m;
    m = word;
    case (funct3[1:0])
      2'b00:   m[{lane, 3'b000} +: 8]       = wdata[7:0];
      2'b01:   m[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      default: m = wdata;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [2:0] funct3,
                                               input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (funct3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'h0, b};
      3'b101:  r = {16'h0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Legality of the incoming request, evaluated in IDLE only.
  always_comb begin
    req_fault = 1'b0;
    case (req_funct3)
      3'b000:  req_fault = 1'b0;
      3'b001:  req_fault = req_addr[0];
      3'b010:  req_fault = |req_addr[1:0];
      3'b100:  req_fault = req_write;
      3'b101:  req_fault = req_write | req_addr[0];
      default: req_fault = 1'b1;
    endcase
    if (|(req_addr >> RAMAddrSize)) req_fault = 1'b1;
  end

  always_comb begin
    state_next      = state;
    req_ready       = 1'b0;
    resp_valid      = 1'b0;
    RAMWriteControl = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = req_fault ? RESP : RD;
      end
      RD:      state_next = write_q ? WR : RESP;
      WR: begin
        RAMWriteControl = 1'b1;
        state_next      = RESP;
      end
      default: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  assign accept = (state == IDLE) && req_valid;

  // RAMAddr is loaded at acceptance so the RAM read word is already valid throughout RD.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      write_q    <= 1'b0;
      resp_rdata <= '0;
      resp_fault <= 1'b0;
      RAMAddr    <= '0;
      DataIn     <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        write_q    <= req_write;
        resp_fault <= req_fault;
        resp_rdata <= '0;
        if (!req_fault) RAMAddr <= {req_addr[RAMAddrSize-1:2], 2'b00};
      end
      // RD exit: the RAM word is captured straight into the merged store word or the load result.
      if (state == RD) begin
        if (write_q) DataIn     <= merge_store(RAMOut, wdata_q, funct3_q, lane_q);
        else         resp_rdata <= extract_load(RAMOut, funct3_q, lane_q);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      funct3_q <= req_funct3;
      lane_q   <= req_addr[1:0];
      wdata_q  <= req_wdata;
    end
  end

endmodule

// File: tb/tb_ram_lsu.sv
// Directed bench for ram_lsu: a vector table of single requests against a behavioural RAM,
// plus hand-written reset sequences.
module tb_ram_lsu;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [7:0]  RAMAddr;
  logic [31:0] DataIn;
  logic        RAMWriteControl;
  logic [31:0] RAMOut;

  logic [31:0] mem [64];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        fault;
    logic [31:0] rdata;
    logic [31:0] din;
    int          lat;
  } vec_t;

  vec_t vecs [17];

  ram_lsu #(.dataW(32), .RAMAddrSize(8)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .RAMAddr(RAMAddr), .DataIn(DataIn), .RAMWriteControl(RAMWriteControl), .RAMOut(RAMOut)
  );

  always #5 clock = ~clock;

  assign RAMOut = mem[RAMAddr[7:2]];
  always @(posedge clock) if (RAMWriteControl) mem[RAMAddr[7:2]] <= DataIn;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Entered and left at a falling edge with the DUT idle.
  task automatic run_vec(input int idx, input vec_t v);
    int          lat;
    int          wr_cnt;
    logic [31:0] wa;
    logic [31:0] wd;
    string       tag;
    tag = $sformatf("v%0d", idx);
    lat = 0; wr_cnt = 0; wa = 32'h0; wd = 32'h0;
    req_valid  = 1'b1;
    req_write  = v.write;
    req_funct3 = v.funct3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    check({tag, " ready"}, 32'(req_ready), 32'd1);
    @(posedge clock);
    #1 req_valid = 1'b0;
    for (int n = 1; n <= 8 && lat == 0; n++) begin
      @(negedge clock);
      if (RAMWriteControl) begin
        wr_cnt++;
        wa = 32'(RAMAddr);
        wd = DataIn;
      end
      if (resp_valid) begin
        lat = n;
        check({tag, " fault"}, 32'(resp_fault), 32'(v.fault));
        check({tag, " rdata"}, resp_rdata, v.rdata);
      end
    end
    check({tag, " latency"}, 32'(lat), 32'(v.lat));
    check({tag, " write cycles"}, 32'(wr_cnt), (v.write && !v.fault) ? 32'd1 : 32'd0);
    if (v.write && !v.fault) begin
      check({tag, " RAMAddr"}, wa, {v.addr[31:2], 2'b00});
      check({tag, " DataIn"}, wd, v.din);
    end
    @(negedge clock);
    check({tag, " pulse width"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    int seen;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    //          write  f3      addr    wdata         fault rdata         din           lat
    vecs[0]  = '{1'b1, 3'b010, 32'h40, 32'hDEADBEEF, 1'b0, 32'h00000000, 32'hDEADBEEF, 3};
    vecs[1]  = '{1'b0, 3'b010, 32'h40, 32'h0,        1'b0, 32'hDEADBEEF, 32'h0,        2};
    vecs[2]  = '{1'b1, 3'b000, 32'h41, 32'h000000AA, 1'b0, 32'h00000000, 32'hDEADAAEF, 3};
    vecs[3]  = '{1'b0, 3'b000, 32'h41, 32'h0,        1'b0, 32'hFFFFFFAA, 32'h0,        2};
    vecs[4]  = '{1'b0, 3'b100, 32'h41, 32'h0,        1'b0, 32'h000000AA, 32'h0,        2};
    vecs[5]  = '{1'b1, 3'b001, 32'h42, 32'h00001234, 1'b0, 32'h00000000, 32'h1234AAEF, 3};
    vecs[6]  = '{1'b0, 3'b001, 32'h42, 32'h0,        1'b0, 32'h00001234, 32'h0,        2};
    vecs[7]  = '{1'b0, 3'b101, 32'h40, 32'h0,        1'b0, 32'h0000AAEF, 32'h0,        2};
    vecs[8]  = '{1'b0, 3'b010, 32'h42, 32'h0,        1'b1, 32'h00000000, 32'h0,        1};
    vecs[9]  = '{1'b1, 3'b001, 32'h41, 32'h00005555, 1'b1, 32'h00000000, 32'h0,        1};
    vecs[10] = '{1'b0, 3'b011, 32'h40, 32'h0,        1'b1, 32'h00000000, 32'h0,        1};
    vecs[11] = '{1'b0, 3'b010, 32'h100, 32'h0,       1'b1, 32'h00000000, 32'h0,        1};
    vecs[12] = '{1'b1, 3'b000, 32'h43, 32'hFFFFFF80, 1'b0, 32'h00000000, 32'h8034AAEF, 3};
    vecs[13] = '{1'b0, 3'b000, 32'h43, 32'h0,        1'b0, 32'hFFFFFF80, 32'h0,        2};
    vecs[14] = '{1'b0, 3'b001, 32'h40, 32'h0,        1'b0, 32'hFFFFAAEF, 32'h0,        2};
    vecs[15] = '{1'b1, 3'b100, 32'h40, 32'h12345678, 1'b1, 32'h00000000, 32'h0,        1};
    vecs[16] = '{1'b0, 3'b010, 32'h8034AAEC, 32'h0,  1'b1, 32'h00000000, 32'h0,        1};

    // Reset state.
    repeat (2) @(negedge clock);
    check("rst RAMWriteControl", 32'(RAMWriteControl), 32'd0);
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    check("rst RAMAddr", 32'(RAMAddr), 32'd0);
    check("rst DataIn", DataIn, 32'd0);
    check("rst req_ready", 32'(req_ready), 32'd1);
    check("rst resp_rdata", resp_rdata, 32'd0);
    check("rst resp_fault", 32'(resp_fault), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 17; i++) run_vec(i, vecs[i]);

    // Faulting request must leave RAMAddr and DataIn at their previous values.
    check("hold RAMAddr", 32'(RAMAddr), 32'h40);
    check("hold DataIn", DataIn, 32'h8034AAEF);

    // Reset during the write cycle of SW 0x44.
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h44; req_wdata = 32'h11111111;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("abort in WR", 32'(RAMWriteControl), 32'd1);
    check("abort DataIn", DataIn, 32'h11111111);
    check("abort RAMAddr", 32'(RAMAddr), 32'h44);
    #1 reset = 1'b1;
    #1;
    check("abort RAMWriteControl", 32'(RAMWriteControl), 32'd0);
    check("abort req_ready", 32'(req_ready), 32'd1);
    check("abort RAMAddr reset", 32'(RAMAddr), 32'd0);
    check("abort DataIn reset", DataIn, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    seen = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clock);
      if (resp_valid || RAMWriteControl) seen++;
    end
    check("abort no response", 32'(seen), 32'd0);
    run_vec(17, '{1'b0, 3'b010, 32'h44, 32'h0, 1'b0, 32'h00000000, 32'h0, 2});
    run_vec(18, '{1'b0, 3'b010, 32'h40, 32'h0, 1'b0, 32'h8034AAEF, 32'h0, 2});

    // req_valid held high through a load: one accept, then a second accept only once idle.
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40;
    seen = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clock);
      if (resp_valid) seen++;
    end
    req_valid = 1'b0;
    check("busy ignores req_valid", 32'(seen), 32'd2);
    repeat (4) @(negedge clock);
    check("busy idle again", 32'(req_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
